load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 43 ++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// width codes and the default data-memory size.
package lsu_pkg;

   localparam int MEM_BYTES_DEF = 128;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      MRG  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Stores only know signed widths; the unsigned codes are load-only.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: load lane extraction with sign/zero extension, and store
// lane merging into a previously read word. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  byte_off_i,
   input  logic [31:0] rd_word_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o
);

   logic [4:0]  shamt;
   logic [31:0] lane;
   logic [31:0] mask;

   assign shamt = {byte_off_i, 3'b000};
   assign lane  = rd_word_i >> shamt;

   always_comb begin
      ld_data_o = rd_word_i;
      case (funct3_i)
         F3_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
         F3_BU:   ld_data_o = {24'd0, lane[7:0]};
         F3_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
         F3_HU:   ld_data_o = {16'd0, lane[15:0]};
         default: ld_data_o = rd_word_i;
      endcase
   end

   always_comb begin
      mask = 32'hFFFF_FFFF;
      case (funct3_i)
         F3_B:    mask = 32'h0000_00FF << shamt;
         F3_H:    mask = 32'h0000_FFFF << shamt;
         default: mask = 32'hFFFF_FFFF;
      endcase
   end

   assign st_word_o = (rd_word_i & ~mask) | ((st_data_i << shamt) & mask);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: validates a request, then drives a
// word-wide memory with read, read-modify-write or direct write sequences.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] address,
   output logic [31:0] write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] read_data
);

   localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

   state_t      state_q, state_d;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        req_err;
   logic        misaligned;
   logic        accept;
   logic [31:0] ld_data;
   logic [31:0] st_word;

   assign accept = (state_q == IDLE) && req_valid;

   always_comb begin
      misaligned = 1'b0;
      case (req_funct3)
         F3_H, F3_HU: misaligned = req_addr[0];
         F3_W:        misaligned = (req_addr[1:0] != 2'b00);
         default:     misaligned = 1'b0;
      endcase
   end

   assign req_err = !f3_legal(req_we, req_funct3) || misaligned ||
                    ({req_addr[31:2], 2'b00} > LAST_WORD);

   lsu_align u_align (
      .funct3_i   (f3_q),
      .byte_off_i (addr_q[1:0]),
      .rd_word_i  (read_data),
      .st_data_i  (word_q),
      .ld_data_o  (ld_data),
      .st_word_o  (st_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= 32'd0;
         word_q  <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else if (accept) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         word_q  <= req_wdata;
         rdata_q <= 32'd0;
         err_q   <= req_err;
      end else if (state_q == MRG) begin
         // Stores keep the merged word for WR; loads keep the extended lane.
         if (we_q) word_q  <= st_word;
         else      rdata_q <= ld_data;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_err)                        state_d = RESP;
               else if (req_we && req_funct3 == F3_W) state_d = WR;
               else                                state_d = RD;
            end
         end
         RD:      state_d = MRG;
         MRG:     state_d = we_q ? WR : RESP;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == IDLE);
      mem_read   = (state_q == RD);
      mem_write  = (state_q == WR);
      resp_valid = (state_q == RESP);
      resp_err   = (state_q == RESP) && err_q;
      resp_rdata = 32'd0;
      address    = 32'd0;
      write_data = 32'd0;
      if (state_q == RD || state_q == WR) address = {addr_q[31:2], 2'b00};
      if (state_q == WR) write_data = word_q;
      if (state_q == RESP && !err_q && !we_q) resp_rdata = rdata_q;
   end

endmodule
